iter_alu: RTL

- Parametrised, registered successor to the single-cycle datapath ALU.
- Adds AND, SLT, and iterative unsigned multiply/divide with HI/LO result registers; supports arbitrary WIDTH.
- Uses a valid/ready input handshake and a one-cycle output-valid pulse.
- Sits in the EX stage. The pipeline stalls on in_ready=0.

---
 rtl/iter_alu_pkg.sv | 12 +
 rtl/iter_muldiv.sv | 65 ++++++
 rtl/iter_alu.sv | 87 ++++++++
 3 files changed

// File: rtl/iter_alu_pkg.sv
// iter_alu_pkg: op codes and muldiv FSM states shared by the iterative ALU
package iter_alu_pkg;
  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_OR    = 4'd2;
  localparam logic [3:0] OP_SLL   = 4'd3;
  localparam logic [3:0] OP_AND   = 4'd4;
  localparam logic [3:0] OP_SLT   = 4'd5;
  localparam logic [3:0] OP_MULTU = 4'd6;
  localparam logic [3:0] OP_DIVU  = 4'd7;
  typedef enum logic {S_IDLE, S_ITER} state_t;
endpackage

// File: rtl/iter_muldiv.sv
// iter_muldiv: one-bit-per-cycle shift-add multiplier and restoring divider
module iter_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_is_div,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy
);
  import iter_alu_pkg::*;
  localparam int CW = $clog2(WIDTH);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [WIDTH-1:0] r_hi, r_lo, r_b, w_hi, w_lo;
  logic r_div, r_done, w_last;
  logic [WIDTH:0] w_sum, w_acc, w_rem, w_diff;
  // lo holds the multiplier (shifted out LSB-first) or the dividend (shifted out MSB-first)
  always_comb begin
    w_last = r_state == S_ITER && r_cnt == '0;
    w_next = r_state == S_IDLE ? (i_start ? S_ITER : S_IDLE) : (w_last ? S_IDLE : S_ITER);
    w_sum = {1'b0, r_hi} + {1'b0, r_b};
    w_acc = r_lo[0] ? w_sum : {1'b0, r_hi};
    w_rem = {r_hi, r_lo[WIDTH-1]};
    w_diff = w_rem - {1'b0, r_b};
    w_hi = r_div ? (w_diff[WIDTH] ? w_rem[WIDTH-1:0] : w_diff[WIDTH-1:0]) : w_acc[WIDTH:1];
    w_lo = r_div ? {r_lo[WIDTH-2:0], ~w_diff[WIDTH]} : {w_acc[0], r_lo[WIDTH-1:1]};
  end
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_b    <= '0;
      r_div  <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_last;
      if (r_state == S_IDLE && i_start) begin
        r_cnt <= CW'(WIDTH - 1);
        r_hi  <= '0;
        r_lo  <= i_a;
        r_b   <= i_b;
        r_div <= i_is_div;
      end else if (r_state == S_ITER) begin
        r_cnt <= r_cnt - CW'(1);
        r_hi  <= w_hi;
        r_lo  <= w_lo;
      end
    end
  end
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_busy = r_state == S_ITER;
endmodule

// File: rtl/iter_alu.sv
// iter_alu: registered ALU with single-cycle ops and iterative MULTU/DIVU into HI/LO
module iter_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   s,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             positive,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);
  import iter_alu_pkg::*;
  logic w_accept, w_md, w_done;
  logic [WIDTH-1:0] w_md_hi, w_md_lo, w_alu, w_res;
  logic r_v;
  logic [3:0] r_op;
  logic [WIDTH-1:0] r_a, r_b;
  logic [SHW-1:0] r_s;
  always_comb begin
    w_accept = in_valid && in_ready;
    w_md = op == OP_MULTU || op == OP_DIVU;
    w_alu = r_op == OP_SUB ? r_a - r_b :
            r_op == OP_OR  ? r_a | r_b :
            r_op == OP_SLL ? r_b << r_s :
            r_op == OP_AND ? r_a & r_b :
            r_op == OP_SLT ? WIDTH'($signed(r_a) < $signed(r_b)) :
            r_a + r_b;
    w_res = w_done ? w_md_lo : w_alu;
  end
  assign in_ready = ~busy;
  iter_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_accept && w_md),
    .i_is_div (op == OP_DIVU),
    .i_a      (a),
    .i_b      (b),
    .o_done   (w_done),
    .o_hi     (w_md_hi),
    .o_lo     (w_md_lo),
    .o_busy   (busy)
  );
  // a single-cycle result and a muldiv completion never land on the same edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_v       <= 1'b0;
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_s       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      positive  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      r_v       <= w_accept && !w_md;
      out_valid <= r_v || w_done;
      if (w_accept) begin
        r_op <= op;
        r_a  <= a;
        r_b  <= b;
        r_s  <= s;
      end
      if (r_v || w_done) begin
        result   <= w_res;
        zero     <= w_res == '0;
        positive <= !w_res[WIDTH-1] && w_res != '0;
      end
      if (w_done) begin
        hi <= w_md_hi;
        lo <= w_md_lo;
      end
    end
  end
endmodule
